// File: rtl/pixelstream_timing_gen_if.sv
// Ready/valid pixel stream carrying {red,green,blue} words and a start-of-frame marker.
interface pixelstream_timing_gen_if #(
    parameter int COLOR_BITS = 8
);
    logic [3*COLOR_BITS-1:0] in_data;
    logic                    in_sop;
    logic                    in_valid;
    logic                    in_ready;

    modport master (output in_data, output in_sop, output in_valid, input in_ready);
    modport slave  (input in_data, input in_sop, input in_valid, output in_ready);
endinterface

// File: rtl/pixelstream_timing_gen.sv
// LCD pixel-stream engine: FIFO-buffered SOP-framed pixels replayed against
// parametrised panel timing, resynchronising to the frame origin after any slip.
module pixelstream_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 48,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 32,
    parameter int COLOR_BITS = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic                      enable,
    pixelstream_timing_gen_if.slave   pix_in,
    output logic [COLOR_BITS-1:0]     lcd_red,
    output logic [COLOR_BITS-1:0]     lcd_green,
    output logic [COLOR_BITS-1:0]     lcd_blue,
    output logic                      lcd_hsync,
    output logic                      lcd_vsync,
    output logic                      lcd_de,
    output logic                      lcd_dclk,
    output logic                      lcd_dclk_en,
    output logic                      frame_start,
    output logic                      underflow,
    input  logic                      clear_status,
    output logic [15:0]               frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 3 * COLOR_BITS;

    typedef enum logic [1:0] {IDLE, SYNCING, STREAM} state_t;

    state_t            state, state_next;
    logic [DW-1:0]     div_cnt, div_next;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [PW-1:0]     pix;
    logic [PW:0]       mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push, pop, show, set_uf;
    logic              tick, h_last, v_last, active, origin, hs_win, vs_win;
    logic              head_sop;
    logic [PW-1:0]     head_data;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix_in.in_ready = !full;
    assign push      = pix_in.in_valid && !full;
    assign head_sop  = mem[rd_ptr[AW-1:0]][PW];
    assign head_data = mem[rd_ptr[AW-1:0]][PW-1:0];

    assign tick     = (state != IDLE) && (int'(div_cnt) == CLK_DIV - 1);
    assign div_next = (int'(div_cnt) == CLK_DIV - 1) ? '0 : div_cnt + DW'(1);
    assign h_last   = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last   = (int'(v_cnt) == V_TOTAL - 1);
    assign active   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign origin   = (h_cnt == '0) && (v_cnt == '0);
    assign hs_win   = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_win   = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

    assign lcd_red   = pix[PW-1 -: COLOR_BITS];
    assign lcd_green = pix[2*COLOR_BITS-1 -: COLOR_BITS];
    assign lcd_blue  = pix[COLOR_BITS-1:0];

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {pix_in.in_sop, pix_in.in_data};
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // SYNCING drains stale words until an SOP head lines up with the origin;
    // STREAM falls back to SYNCING on an empty FIFO or an SOP that arrives early.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        show       = 1'b0;
        set_uf     = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = SYNCING;
                SYNCING: begin
                    if (!empty && !head_sop) begin
                        pop = 1'b1;
                    end else if (!empty && tick && origin) begin
                        pop        = 1'b1;
                        show       = 1'b1;
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    if (tick && active) begin
                        if (empty || (head_sop && !origin)) begin
                            set_uf     = 1'b1;
                            state_next = SYNCING;
                        end else begin
                            pop  = 1'b1;
                            show = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Every panel output is registered on the tick from one counter snapshot.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix         <= '0;
            lcd_de      <= 1'b0;
            lcd_hsync   <= ~HSYNC_POL;
            lcd_vsync   <= ~VSYNC_POL;
            lcd_dclk    <= 1'b0;
            lcd_dclk_en <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            lcd_dclk_en <= (state_next != IDLE);
            frame_start <= 1'b0;
            if (state == IDLE || state_next == IDLE) begin
                div_cnt   <= '0;
                h_cnt     <= '0;
                v_cnt     <= '0;
                pix       <= '0;
                lcd_de    <= 1'b0;
                lcd_hsync <= ~HSYNC_POL;
                lcd_vsync <= ~VSYNC_POL;
                lcd_dclk  <= 1'b0;
            end else begin
                div_cnt  <= div_next;
                lcd_dclk <= (int'(div_next) >= CLK_DIV / 2);
                if (tick) begin
                    pix         <= show ? head_data : '0;
                    lcd_de      <= active;
                    lcd_hsync   <= hs_win ? HSYNC_POL : ~HSYNC_POL;
                    lcd_vsync   <= vs_win ? VSYNC_POL : ~VSYNC_POL;
                    frame_start <= origin;
                    if (h_last) begin
                        h_cnt <= '0;
                        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
                        if (v_last) frame_count <= frame_count + 16'd1;
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
            end
        end
    end

    // A set in the same cycle as clear_status wins.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)       underflow <= 1'b0;
        else if (set_uf)       underflow <= 1'b1;
        else if (clear_status) underflow <= 1'b0;
    end
endmodule

// File: tb/tb_pixelstream_timing_gen.sv
// Directed bench for pixelstream_timing_gen on a 7x5-tick frame (H 4/1/1/1, V 2/1/1/1, CLK_DIV 2).
module tb_pixelstream_timing_gen;
    localparam int CB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear_status = 1'b0;
    logic [CB-1:0] lcd_red, lcd_green, lcd_blue;
    logic        lcd_hsync, lcd_vsync, lcd_de, lcd_dclk, lcd_dclk_en;
    logic        frame_start, underflow;
    logic [15:0] frame_count;
    int          check_count = 0;
    int          pass_count = 0;
    int          n;
    logic [23:0] exp_pix [8];

    pixelstream_timing_gen_if #(.COLOR_BITS(CB)) stream_if ();

    pixelstream_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(CB), .FIFO_DEPTH(16), .CLK_DIV(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .enable(enable),
        .pix_in(stream_if.slave),
        .lcd_red(lcd_red),
        .lcd_green(lcd_green),
        .lcd_blue(lcd_blue),
        .lcd_hsync(lcd_hsync),
        .lcd_vsync(lcd_vsync),
        .lcd_de(lcd_de),
        .lcd_dclk(lcd_dclk),
        .lcd_dclk_en(lcd_dclk_en),
        .frame_start(frame_start),
        .underflow(underflow),
        .clear_status(clear_status),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic [23:0] data, input logic sop);
        int k = 0;
        stream_if.in_data  = data;
        stream_if.in_sop   = sop;
        stream_if.in_valid = 1'b1;
        while (stream_if.in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("push_ready", 32'(stream_if.in_ready), 32'd1);
        @(negedge clk);
        stream_if.in_valid = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rgb"}, 32'({lcd_red, lcd_green, lcd_blue}), 32'd0);
        checkOutput({tag, "_de"}, 32'(lcd_de), 32'd0);
        checkOutput({tag, "_hsync"}, 32'(lcd_hsync), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(lcd_vsync), 32'd1);
        checkOutput({tag, "_dclk"}, 32'(lcd_dclk), 32'd0);
        checkOutput({tag, "_dclk_en"}, 32'(lcd_dclk_en), 32'd0);
        checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        checkOutput({tag, "_underflow"}, 32'(underflow), 32'd0);
        checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(stream_if.in_ready), 32'd1);
    endtask

    task automatic waitFrameStart();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 300);
        checkOutput("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    // Walks all 35 ticks of one frame; tick t sits at h = t%7, v = t/7.
    task automatic checkFrame(input bit wait_start);
        int h, v;
        logic in_act;
        logic [23:0] exp_rgb;
        if (wait_start) waitFrameStart();
        for (int t = 0; t < 35; t++) begin
            if (t > 0) @(negedge clk);
            h = t % 7;
            v = t / 7;
            in_act  = (h < 4) && (v < 2);
            exp_rgb = in_act ? exp_pix[v*4 + h] : 24'h0;
            checkOutput($sformatf("de t%0d", t), 32'(lcd_de), 32'(in_act));
            checkOutput($sformatf("hsync t%0d", t), 32'(lcd_hsync), (h == 5) ? 32'd0 : 32'd1);
            checkOutput($sformatf("vsync t%0d", t), 32'(lcd_vsync), (v == 3) ? 32'd0 : 32'd1);
            checkOutput($sformatf("rgb t%0d", t), 32'({lcd_red, lcd_green, lcd_blue}), 32'(exp_rgb));
            checkOutput($sformatf("frame_start t%0d", t), 32'(frame_start), (t == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("dclk_low t%0d", t), 32'(lcd_dclk), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("dclk_high t%0d", t), 32'(lcd_dclk), 32'd1);
            checkOutput($sformatf("dclk_en t%0d", t), 32'(lcd_dclk_en), 32'd1);
            checkOutput($sformatf("fs_pulse t%0d", t), 32'(frame_start), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stream_if.in_data  = '0;
        stream_if.in_sop   = 1'b0;
        stream_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        // Free-running timing with no input
        enable  = 1'b1;
        exp_pix = '{default: 24'h0};
        checkFrame(1'b1);
        checkOutput("frame_count_1", 32'(frame_count), 32'd1);
        checkOutput("underflow_no_input", 32'(underflow), 32'd0);
        waitFrameStart();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        checkOutput("frame_period", 32'(n), 32'd70);
        waitFrameStart();
        checkOutput("frame_count_3", 32'(frame_count), 32'd3);

        // Full frame preloaded before the origin
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) applyStimulus(24'(i + 1), i == 0);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) exp_pix[i] = 24'(i + 1);
        checkFrame(1'b1);
        checkOutput("underflow_full_frame", 32'(underflow), 32'd0);

        // Short frame underflows
        enable = 1'b0;
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(24'(i + 1), i == 0);
        enable  = 1'b1;
        exp_pix = '{24'h1, 24'h2, 24'h3, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        checkFrame(1'b1);
        checkOutput("underflow_set", 32'(underflow), 32'd1);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        checkOutput("underflow_cleared", 32'(underflow), 32'd0);

        // Stale non-SOP words are discarded before the SOP frame
        waitFrameStart();
        applyStimulus(24'hAA0001, 1'b0);
        applyStimulus(24'hAA0002, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(24'h000011 + 24'(i), i == 0);
        for (int i = 0; i < 8; i++) exp_pix[i] = 24'h000011 + 24'(i);
        checkFrame(1'b1);
        checkOutput("underflow_after_discard", 32'(underflow), 32'd0);

        // Early SOP on word 5 aborts the frame; it restarts there next origin
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) applyStimulus(24'h000020 + 24'(i), (i == 0) || (i == 5));
        enable  = 1'b1;
        exp_pix = '{24'h20, 24'h21, 24'h22, 24'h23, 24'h24, 24'h0, 24'h0, 24'h0};
        checkFrame(1'b1);
        checkOutput("underflow_early_sop", 32'(underflow), 32'd1);
        exp_pix = '{24'h25, 24'h26, 24'h27, 24'h28, 24'h29, 24'h0, 24'h0, 24'h0};
        checkFrame(1'b1);

        // Backpressure: fill all 16 entries while idle
        enable = 1'b0;
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(24'h000040 + 24'(i), i == 0);
        stream_if.in_data  = 24'hBAD000;
        stream_if.in_sop   = 1'b0;
        stream_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("in_ready_full c%0d", i), 32'(stream_if.in_ready), 32'd0);
            @(negedge clk);
        end
        stream_if.in_valid = 1'b0;
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 10) begin
            checkOutput("in_ready_before_pop", 32'(stream_if.in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_after_pop", 32'(stream_if.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) exp_pix[i] = 24'h000040 + 24'(i);
        checkFrame(1'b0);
        for (int i = 0; i < 8; i++) exp_pix[i] = 24'h000048 + 24'(i);
        checkFrame(1'b1);
        checkOutput("underflow_full_fifo", 32'(underflow), 32'd0);

        // Drop enable mid-line, then re-enable
        waitFrameStart();
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("disable_dclk_en", 32'(lcd_dclk_en), 32'd0);
        checkOutput("disable_hsync", 32'(lcd_hsync), 32'd1);
        checkOutput("disable_vsync", 32'(lcd_vsync), 32'd1);
        checkOutput("disable_de", 32'(lcd_de), 32'd0);
        checkOutput("disable_dclk", 32'(lcd_dclk), 32'd0);
        checkOutput("disable_rgb", 32'({lcd_red, lcd_green, lcd_blue}), 32'd0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 20);
        checkOutput("reenable_origin_latency", 32'(n), 32'd3);
        exp_pix = '{default: 24'h0};
        checkFrame(1'b0);

        // Asynchronous reset mid-frame
        waitFrameStart();
        checkOutput("pre_reset_de", 32'(lcd_de), 32'd1);
        #2 rst = 1'b1;
        #1 checkReset("async_reset");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
